// File: rtl/rng_uni_gen.sv
// rng_uni_gen: lagged-XOR uniform random word generator.
// W shift-register lanes of slightly different depths feed a permuted,
// XOR-mixed output word that is fed back into the lanes, forming one long
// ring of SEED_LEN bits. A serial seed fully overwrites that ring, an
// optional warm-up discards early words, then words are handed out under a
// valid/ready handshake.
// Optional feature: define RNG_UNI_GEN_CNT_EN to build the accepted-word
// counter on word_cnt; otherwise word_cnt is tied to zero.

module rng_uni_gen #(
  parameter int W       = 32,
  parameter int DEPTH   = 32,
  parameter int TAP_A   = 11,
  parameter int TAP_B   = 20,
  parameter int PSTRIDE = 13,
  parameter int WARMUP  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         seed_valid,
  input  logic         seed_data,
  output logic         seed_ready,
  output logic [W-1:0] rng_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         s_out,
  output logic [31:0]  word_cnt
);

  // Depth of lane i; depths cycle DEPTH, DEPTH-1, DEPTH-2, DEPTH-3 so the
  // lanes never stay phase-aligned with each other.
  function automatic int laneDepth(input int i);
    return DEPTH - ((5 * i) % 4);
  endfunction

  // Output bit position that lane i writes; PSTRIDE odd and W a power of
  // two make this a bijection.
  function automatic int permIdx(input int i);
    return (i * PSTRIDE) % W;
  endfunction

  // Total ring length: every lane bit plus every output bit.
  function automatic int seedLen();
    int s;
    s = 0;
    for (int i = 0; i < W; i++) begin
      s += laneDepth(i);
    end
    return s + W;
  endfunction

  localparam logic [31:0] SEED_LAST = 32'(seedLen() - 1);
  localparam logic [31:0] WARM_LAST = 32'(WARMUP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_WARMUP,
    ST_RUN
  } state_t;

  state_t        state_q;
  logic          seedReady_q;
  logic          outValid_q;
  logic [31:0]   seedCnt_q;
  logic [31:0]   warmCnt_q;
  logic [W-1:0]  rngOut_q;
  logic [W-1:0]  rngOut_d;
  logic [W-1:0]  fifoOut;
  logic [W-1:0]  laneIn;
  logic          seedStep;
  logic          genStep;
  logic          laneShift;

  // Decide whether this cycle is a seed step, a generate step or neither;
  // start suppresses any step in the cycle it is seen.
  always_comb begin
    seedStep = 1'b0;
    genStep  = 1'b0;
    if (!start) begin
      case (state_q)
        ST_SEED:   seedStep = seed_valid;
        ST_WARMUP: genStep  = 1'b1;
        ST_RUN:    genStep  = out_ready;
        default:   ;
      endcase
    end
  end

  assign laneShift = seedStep | genStep;

  // Next output word: seed steps pass lane outputs straight through and
  // inject the serial seed bit, generate steps XOR three lanes together.
  always_comb begin
    rngOut_d = rngOut_q;
    if (seedStep) begin
      for (int i = 0; i < W - 1; i++) begin
        rngOut_d[permIdx(i)] = fifoOut[i];
      end
      rngOut_d[permIdx(W - 1)] = seed_data;
    end else if (genStep) begin
      for (int i = 0; i < W; i++) begin
        rngOut_d[permIdx(i)] = fifoOut[i]
                             ^ fifoOut[(i + TAP_A) % W]
                             ^ fifoOut[(i + TAP_B) % W];
      end
    end
  end

  // One shift register per lane, each with its own depth; lane i is fed
  // from the output bit that lane i+1 wrote, closing the ring.
  for (genvar g = 0; g < W; g++) begin : gLane
    localparam int K   = DEPTH - ((5 * g) % 4);
    localparam int SRC = (((g + 1) % W) * PSTRIDE) % W;

    logic [K-1:0] sr_q;

    assign laneIn[g]  = rngOut_q[SRC];
    assign fifoOut[g] = sr_q[K-1];

    // Shift the lane on every step, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sr_q <= '0;
      end else if (laneShift) begin
        sr_q <= {sr_q[K-2:0], laneIn[g]};
      end
    end
  end

  // Output word register; rngOut_d already holds the old value when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rngOut_q <= '0;
    end else begin
      rngOut_q <= rngOut_d;
    end
  end

  // Control FSM with registered seed_ready/out_valid that track the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      seedCnt_q   <= '0;
      warmCnt_q   <= '0;
      seedReady_q <= 1'b0;
      outValid_q  <= 1'b0;
    end else if (start) begin
      state_q     <= ST_SEED;
      seedCnt_q   <= '0;
      warmCnt_q   <= '0;
      seedReady_q <= 1'b1;
      outValid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_SEED: begin
          if (seed_valid) begin
            seedCnt_q <= seedCnt_q + 32'd1;
            if (seedCnt_q == SEED_LAST) begin
              seedReady_q <= 1'b0;
              if (WARMUP == 0) begin
                state_q    <= ST_RUN;
                outValid_q <= 1'b1;
              end else begin
                state_q <= ST_WARMUP;
              end
            end
          end
        end
        ST_WARMUP: begin
          warmCnt_q <= warmCnt_q + 32'd1;
          if (warmCnt_q == WARM_LAST) begin
            state_q    <= ST_RUN;
            outValid_q <= 1'b1;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RNG_UNI_GEN_CNT_EN
  logic [31:0] wordCnt_q;

  // Count accepted words; restarts from zero on every (re)seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordCnt_q <= '0;
    end else if (start) begin
      wordCnt_q <= '0;
    end else if (genStep && (state_q == ST_RUN)) begin
      wordCnt_q <= wordCnt_q + 32'd1;
    end
  end

  assign word_cnt = wordCnt_q;
`else
  assign word_cnt = 32'd0;
`endif

  assign seed_ready = seedReady_q;
  assign out_valid  = outValid_q;
  assign rng_out    = rngOut_q;
  assign s_out      = fifoOut[W-1];

endmodule
